// File: rtl/bayer_pkg.sv
// Shared constants for the Bayer demosaic front end: default pixel width,
// controller state encoding and the position of a pixel inside its 2x2 quad.
package bayer_pkg;

    localparam int BAYER_DATA_W = 12;

    // Frame controller states
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Quad positions, encoded as {row_odd, col_odd}.
    // Even rows carry G1 R G1 R..., odd rows carry B G2 B G2...
    localparam logic [1:0] POS_G1 = 2'd0;
    localparam logic [1:0] POS_R  = 2'd1;
    localparam logic [1:0] POS_B  = 2'd2;
    localparam logic [1:0] POS_G2 = 2'd3;

    function automatic logic [1:0] quad_pos(input logic row_odd, input logic col_odd);
        return {row_odd, col_odd};
    endfunction

endpackage

// File: rtl/raw_line_buffer.sv
// Simple dual-port RAM holding one half-resolution line of {G1, R} pairs.
// Synchronous read with one cycle of latency and no reset on the array,
// so it maps onto a single block RAM.
module raw_line_buffer
    import bayer_pkg::*;
#(
    parameter int WIDTH  = 2 * BAYER_DATA_W,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bayer_to_rgb.sv
// Demosaics a raw Bayer stream (G1 R / B G2 quads) into one 8-bit RGB pixel
// per 2x2 quad. The even row is parked in a half-line buffer as {G1, R} and
// combined with B and G2 while the odd row streams in.
module bayer_to_rgb
    import bayer_pkg::*;
#(
    parameter int DATA_W    = BAYER_DATA_W,
    parameter int MAX_WIDTH = 1280,
    parameter int ADDR_W    = 10
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [DATA_W-1:0] iData,
    input  logic              iLineValid,
    input  logic              iFrameValid,
    input  logic              iHSync,
    input  logic              iVSync,
    output logic [7:0]        oR,
    output logic [7:0]        oG,
    output logic [7:0]        oB,
    output logic              oHSync,
    output logic              oVSync,
    output logic              oLineValid,
    output logic              oFrameValid,
    output logic              oOverflow
);

    // One extra bit so the column counter can sit at MAX_WIDTH
    localparam int              CW      = ADDR_W + 2;
    localparam logic [CW-1:0]   MAX_COL = CW'(MAX_WIDTH);
    localparam int              DEPTH   = MAX_WIDTH / 2;

    logic [0:0]          state_reg;
    logic                fv_prev_reg;
    logic                lv_prev_reg;
    logic [CW-1:0]       col_reg;
    logic                row_odd_reg;
    logic [DATA_W-1:0]   g1_reg;
    logic [DATA_W-1:0]   b_reg;

    logic                lv;
    logic                frame_start;
    logic                run;
    logic                pix_ok;
    logic                lv_rise;
    logic                lv_fall;
    logic [CW-1:0]       idx;
    logic                in_range;
    logic                row_odd;
    logic [1:0]          pos;
    logic                wr_en;
    logic                rd_en;
    logic                strobe;
    logic [ADDR_W-1:0]   addr;
    logic [2*DATA_W-1:0] rd_data;
    logic [7:0]          r_next;
    logic [7:0]          g_next;
    logic [7:0]          b_next;

    // Decode the current pixel: edges, column index, quad position and buffer strobes
    always_comb begin
        lv          = iLineValid && iFrameValid;
        frame_start = iFrameValid && !fv_prev_reg;
        run         = (state_reg == ST_ACTIVE) || frame_start;
        pix_ok      = lv && run;
        lv_rise     = lv && !lv_prev_reg;
        lv_fall     = !lv && lv_prev_reg;
        idx         = lv_rise ? '0 : col_reg;
        in_range    = idx < MAX_COL;
        row_odd     = frame_start ? 1'b0 : row_odd_reg;
        pos         = quad_pos(row_odd, idx[0]);
        addr        = idx[ADDR_W:1];
        wr_en       = pix_ok && in_range && (pos == POS_R);
        rd_en       = pix_ok && in_range && (pos == POS_B);
        strobe      = pix_ok && in_range && (pos == POS_G2);
        r_next      = 8'(rd_data[DATA_W-1:0] >> (DATA_W - 8));
        b_next      = 8'(b_reg >> (DATA_W - 8));
        g_next      = 8'(({1'b0, rd_data[2*DATA_W-1:DATA_W]} + {1'b0, iData}) >> (DATA_W - 7));
    end

    raw_line_buffer #(
        .WIDTH  (2 * DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_line_buffer (
        .clk     (iClk),
        .wr_en   (wr_en),
        .wr_addr (addr),
        .wr_data ({g1_reg, iData}),
        .rd_en   (rd_en),
        .rd_addr (addr),
        .rd_data (rd_data)
    );

    // Frame state and edge history. fv_prev resets high so that a reset
    // released in the middle of a frame cannot look like a frame start.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_reg   <= ST_IDLE;
            fv_prev_reg <= 1'b1;
            lv_prev_reg <= 1'b0;
        end else begin
            fv_prev_reg <= iFrameValid;
            lv_prev_reg <= lv;
            if (frame_start) begin
                state_reg <= ST_ACTIVE;
            end else if (!iFrameValid) begin
                state_reg <= ST_IDLE;
            end
        end
    end

    // Column counter (saturates at MAX_WIDTH), row parity and sticky overflow
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            col_reg     <= '0;
            row_odd_reg <= 1'b0;
            oOverflow   <= 1'b0;
        end else if (run) begin
            if (pix_ok) begin
                col_reg <= in_range ? idx + 1'b1 : idx;
            end
            if (frame_start) begin
                row_odd_reg <= 1'b0;
            end else if (lv_fall) begin
                row_odd_reg <= ~row_odd_reg;
            end
            if (frame_start) begin
                oOverflow <= 1'b0;
            end else if (pix_ok && !in_range) begin
                oOverflow <= 1'b1;
            end
        end
    end

    // Hold G1 (even row) and B (odd row) until their partner pixel arrives
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            g1_reg <= '0;
            b_reg  <= '0;
        end else if (pix_ok && in_range) begin
            if (pos == POS_G1) begin
                g1_reg <= iData;
            end else if (pos == POS_B) begin
                b_reg <= iData;
            end
        end
    end

    // Registered outputs: RGB held between strobes, syncs delayed one cycle
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oR          <= '0;
            oG          <= '0;
            oB          <= '0;
            oLineValid  <= 1'b0;
            oHSync      <= 1'b0;
            oVSync      <= 1'b0;
            oFrameValid <= 1'b0;
        end else begin
            oLineValid  <= strobe;
            oHSync      <= iHSync;
            oVSync      <= iVSync;
            oFrameValid <= iFrameValid && run;
            if (strobe) begin
                oR <= r_next;
                oG <= g_next;
                oB <= b_next;
            end
        end
    end

endmodule

// File: tb/tb_bayer_to_rgb.sv
// Bench for bayer_to_rgb: one instance with default sizing and one narrow
// instance (MAX_WIDTH=8) driven from the same stream. Expected RGB pixels
// are queued when the odd-row odd-column pixel is driven and matched when
// each instance strobes.
`timescale 1ns/1ps
module tb_bayer_to_rgb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] data = '0;
    logic        lv = 1'b0, fv = 1'b0, hs = 1'b0, vs = 1'b0;

    logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic        a_hs, a_vs, a_lv, a_fv, a_ovf;
    logic        b_hs, b_vs, b_lv, b_fv, b_ovf;

    bayer_to_rgb dut_a (
        .iClk(clk), .iRst(rst), .iData(data), .iLineValid(lv), .iFrameValid(fv),
        .iHSync(hs), .iVSync(vs), .oR(a_r), .oG(a_g), .oB(a_b), .oHSync(a_hs),
        .oVSync(a_vs), .oLineValid(a_lv), .oFrameValid(a_fv), .oOverflow(a_ovf)
    );

    bayer_to_rgb #(.DATA_W(12), .MAX_WIDTH(8), .ADDR_W(2)) dut_b (
        .iClk(clk), .iRst(rst), .iData(data), .iLineValid(lv), .iFrameValid(fv),
        .iHSync(hs), .iVSync(vs), .oR(b_r), .oG(b_g), .oB(b_b), .oHSync(b_hs),
        .oVSync(b_vs), .oLineValid(b_lv), .oFrameValid(b_fv), .oOverflow(b_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r, g, b;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [11:0] g1, r, b, g2;
        logic [7:0]  er, eg, eb;
    } vec_t;

    exp_t        qa[$], qb[$];
    exp_t        ea, eb;
    vec_t        vecs[6];
    logic [11:0] pix[4][10];
    logic [23:0] fixed_exp[2];
    int          checks = 0, errors = 0, cyc = 0, sa_cnt = 0, sb_cnt = 0;
    logic        hs_d = 1'b0, vs_d = 1'b0, fv_d = 1'b0;
    bit          sync_chk = 1'b0, fv_zero_chk = 1'b0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        hs_d <= hs;
        vs_d <= vs;
        fv_d <= fv;
    end

    // Scoreboard side: match every strobe against the queued expectation
    always @(negedge clk) begin
        if (a_lv) begin
            sa_cnt++;
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL strobe_a unexpected: actual r=%h g=%h b=%h cyc=%0d, required no strobe", a_r, a_g, a_b, cyc);
            end else begin
                ea = qa.pop_front();
                if ({a_r, a_g, a_b} !== {ea.r, ea.g, ea.b} || cyc != ea.cyc) begin
                    errors++;
                    $display("FAIL strobe_a: actual r=%h g=%h b=%h cyc=%0d, required r=%h g=%h b=%h cyc=%0d",
                             a_r, a_g, a_b, cyc, ea.r, ea.g, ea.b, ea.cyc);
                end else begin
                    $display("strobe_a cyc=%0d r=%h g=%h b=%h", cyc, a_r, a_g, a_b);
                end
            end
        end
        if (b_lv) begin
            sb_cnt++;
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL strobe_b unexpected: actual r=%h g=%h b=%h cyc=%0d, required no strobe", b_r, b_g, b_b, cyc);
            end else begin
                eb = qb.pop_front();
                if ({b_r, b_g, b_b} !== {eb.r, eb.g, eb.b} || cyc != eb.cyc) begin
                    errors++;
                    $display("FAIL strobe_b: actual r=%h g=%h b=%h cyc=%0d, required r=%h g=%h b=%h cyc=%0d",
                             b_r, b_g, b_b, cyc, eb.r, eb.g, eb.b, eb.cyc);
                end
            end
        end
        if (sync_chk) begin
            checks++;
            if ({a_hs, a_vs, a_fv, b_fv} !== {hs_d, vs_d, fv_d, fv_d}) begin
                errors++;
                $display("FAIL sync_delay cyc=%0d: actual hs/vs/fv_a/fv_b=%b%b%b%b, required %b%b%b%b",
                         cyc, a_hs, a_vs, a_fv, b_fv, hs_d, vs_d, fv_d, fv_d);
            end
        end
        if (fv_zero_chk) begin
            checks++;
            if ({a_fv, b_fv} !== 2'b00) begin
                errors++;
                $display("FAIL fv_after_reset cyc=%0d: actual fv_a=%b fv_b=%b, required 0", cyc, a_fv, b_fv);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(input logic [11:0] d, input logic l, input logic f);
        @(posedge clk);
        #1;
        data = d;
        lv   = l;
        fv   = f;
        hs   = 1'($urandom_range(0, 1));
        vs   = 1'($urandom_range(0, 1));
    endtask

    function automatic void push(input bit to_b, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t e;
        e.r = r;
        e.g = g;
        e.b = b;
        e.cyc = cyc + 1;
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
    endfunction

    // Drive one frame from pix[][]; expectations come either from the
    // fixed list or from the quad arithmetic on the stored raw pixels.
    task automatic drive_frame(input int w, input int h, input bit use_fixed);
        int k = 0;
        logic [7:0] er, eg, ebb;
        tick(12'h0, 1'b0, 1'b1);
        tick(12'h0, 1'b0, 1'b1);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                tick(pix[r][c], 1'b1, 1'b1);
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    if (use_fixed) begin
                        {er, eg, ebb} = fixed_exp[k];
                        k++;
                    end else begin
                        er  = pix[r-1][c][11:4];
                        ebb = pix[r][c-1][11:4];
                        eg  = 8'((13'(pix[r-1][c-1]) + 13'(pix[r][c])) >> 5);
                    end
                    push(1'b0, er, eg, ebb);
                    if (c < 8) push(1'b1, er, eg, ebb);
                end
            end
            tick(12'h0, 1'b0, 1'b1);
            tick(12'h0, 1'b0, 1'b1);
            tick(12'h0, 1'b0, 1'b1);
        end
        tick(12'h0, 1'b0, 1'b0);
        tick(12'h0, 1'b0, 1'b0);
        tick(12'h0, 1'b0, 1'b0);
    endtask

    task automatic check_counts(input string name, input int exp_a, input int exp_b);
        tick(12'h0, 1'b0, 1'b0);
        tick(12'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk({name, "_count_a"}, sa_cnt, exp_a);
        chk({name, "_count_b"}, sb_cnt, exp_b);
        chk({name, "_pending"}, qa.size() + qb.size(), 0);
        sa_cnt = 0;
        sb_cnt = 0;
        qa.delete();
        qb.delete();
    endtask

    task automatic fill_random(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                pix[r][c] = 12'($urandom_range(0, 4095));
    endtask

    task automatic run_vec(input int i);
        pix[0][0] = vecs[i].g1;
        pix[0][1] = vecs[i].r;
        pix[1][0] = vecs[i].b;
        pix[1][1] = vecs[i].g2;
        fixed_exp[0] = {vecs[i].er, vecs[i].eg, vecs[i].eb};
        drive_frame(2, 2, 1'b1);
        check_counts("vec", 1, 1);
    endtask

    initial begin
        //            g1       r        b        g2       R      G      B
        vecs[0] = '{12'h100, 12'hFF0, 12'h0A0, 12'h300, 8'hFF, 8'h20, 8'h0A};
        vecs[1] = '{12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 8'h00, 8'hFF, 8'hFF};
        vecs[2] = '{12'h001, 12'h00F, 12'h010, 12'h01F, 8'h00, 8'h01, 8'h01};
        vecs[3] = '{12'h800, 12'h7FF, 12'h123, 12'h800, 8'h7F, 8'h80, 8'h12};
        vecs[4] = '{12'hABC, 12'h5A5, 12'hC3C, 12'h123, 8'h5A, 8'h5E, 8'hC3};
        vecs[5] = '{12'h7FF, 12'h800, 12'h00F, 12'h001, 8'h80, 8'h40, 8'h00};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_a", int'({a_r, a_g, a_b, a_hs, a_vs, a_lv, a_fv, a_ovf}), 0);
        chk("reset_outputs_b", int'({b_r, b_g, b_b, b_hs, b_vs, b_lv, b_fv, b_ovf}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(12'h0, 1'b0, 1'b0);
        tick(12'h0, 1'b0, 1'b0);
        sync_chk = 1'b1;

        // Single-quad table, including the green-sum maximum
        for (int i = 0; i < 6; i++) run_vec(i);

        // 4x2 frame with known values
        pix[0][0] = 12'h100; pix[0][1] = 12'hFF0; pix[0][2] = 12'h200; pix[0][3] = 12'h800;
        pix[1][0] = 12'h0A0; pix[1][1] = 12'h300; pix[1][2] = 12'h010; pix[1][3] = 12'h100;
        fixed_exp[0] = {8'hFF, 8'h20, 8'h0A};
        fixed_exp[1] = {8'h80, 8'h18, 8'h01};
        drive_frame(4, 2, 1'b1);
        check_counts("frame4x2", 2, 2);

        // Odd width and odd height
        fill_random(5, 3);
        drive_frame(5, 3, 1'b0);
        check_counts("frame5x3", 2, 2);

        // Overflow on the narrow instance: 10-pixel lines against MAX_WIDTH=8
        fill_random(10, 2);
        drive_frame(10, 2, 1'b0);
        check_counts("overflow", 5, 4);
        chk("overflow_set_b", int'(b_ovf), 1);
        chk("overflow_clear_a", int'(a_ovf), 0);
        tick(12'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("overflow_held_b", int'(b_ovf), 1);
        @(negedge clk);
        chk("overflow_cleared_b", int'(b_ovf), 0);
        run_vec(0);
        chk("overflow_stays_clear_b", int'(b_ovf), 0);

        // Reset asserted during row 1 and released while the frame is still valid
        fill_random(4, 4);
        sync_chk = 1'b0;
        tick(12'h0, 1'b0, 1'b1);
        tick(12'h0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) tick(pix[0][c], 1'b1, 1'b1);
        tick(12'h0, 1'b0, 1'b1);
        tick(12'h0, 1'b0, 1'b1);
        tick(pix[1][0], 1'b1, 1'b1);
        tick(pix[1][1], 1'b1, 1'b1);
        rst = 1'b1;
        tick(pix[1][2], 1'b1, 1'b1);
        tick(pix[1][3], 1'b1, 1'b1);
        rst = 1'b0;
        fv_zero_chk = 1'b1;
        for (int r = 1; r < 4; r++) begin
            tick(12'h0, 1'b0, 1'b1);
            tick(12'h0, 1'b0, 1'b1);
            if (r > 1) for (int c = 0; c < 4; c++) tick(pix[r][c], 1'b1, 1'b1);
        end
        tick(12'h0, 1'b0, 1'b0);
        @(negedge clk);
        fv_zero_chk = 1'b0;
        tick(12'h0, 1'b0, 1'b0);
        tick(12'h0, 1'b0, 1'b0);
        sync_chk = 1'b1;
        check_counts("reset_midframe", 0, 0);
        run_vec(4);

        // Line valid pulses outside a frame are ignored
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < 4; c++) tick(12'($urandom_range(0, 4095)), 1'b1, 1'b0);
            tick(12'h0, 1'b0, 1'b0);
            tick(12'h0, 1'b0, 1'b0);
        end
        check_counts("lv_outside_frame", 0, 0);
        fill_random(4, 2);
        drive_frame(4, 2, 1'b0);
        check_counts("frame_after_stray_lv", 2, 2);

        sync_chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
